// File: rtl/sll_iter.sv
// Iterative 32-bit logical left shifter: one power-of-two stage per clock (16,8,4,2,1),
// with overflow flag for any 1 bit shifted out past bit 31.
module sll_iter (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_SLL,
  input  logic [31:0] data_operand,
  input  logic [4:0]  shiftamt,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        data_exception,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  amt_q, amt_d;
  logic [2:0]  stage_q, stage_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;

  logic [31:0] shifted;
  logic        lost;
  logic        take;

  // Stage datapath: shift by 2^stage and collect the bits pushed past bit 31.
  always_comb begin
    shifted = acc_q;
    lost    = 1'b0;
    take    = 1'b0;
    case (stage_q)
      3'd4: begin shifted = {acc_q[15:0], 16'b0}; lost = |acc_q[31:16]; take = amt_q[4]; end
      3'd3: begin shifted = {acc_q[23:0], 8'b0};  lost = |acc_q[31:24]; take = amt_q[3]; end
      3'd2: begin shifted = {acc_q[27:0], 4'b0};  lost = |acc_q[31:28]; take = amt_q[2]; end
      3'd1: begin shifted = {acc_q[29:0], 2'b0};  lost = |acc_q[31:30]; take = amt_q[1]; end
      3'd0: begin shifted = {acc_q[30:0], 1'b0};  lost = acc_q[31];     take = amt_q[0]; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    amt_d   = amt_q;
    stage_d = stage_q;
    exc_d   = exc_q;
    case (state_q)
      IDLE, DONE: begin
        if (ctrl_SLL) begin
          acc_d   = data_operand;
          amt_d   = shiftamt;
          exc_d   = 1'b0;
          stage_d = 3'd4;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Requests arriving here are dropped, not queued.
        if (take) begin
          acc_d = shifted;
          exc_d = exc_q | lost;
        end
        if (stage_q == 3'd0) state_d = DONE;
        else                 stage_d = stage_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
    rdy_d  = (state_d == DONE);
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      amt_q   <= '0;
      stage_q <= '0;
      exc_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      amt_q   <= amt_d;
      stage_q <= stage_d;
      exc_q   <= exc_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign data_result    = acc_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_sll_iter.sv
// Directed + random bench for sll_iter against a 64-bit arithmetic shift model.
module tb_sll_iter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_SLL;
  logic [31:0] data_operand;
  logic [4:0]  shiftamt;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        data_exception;
  logic        busy;

  int errors = 0;
  int checks = 0;

  sll_iter dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_SLL       (ctrl_SLL),
    .data_operand   (data_operand),
    .shiftamt       (shiftamt),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [31:0] op, input logic [4:0] amt);
    logic [63:0] w;
    w = {32'b0, op} << amt;
    return w[31:0];
  endfunction

  function automatic logic ref_exc(input logic [31:0] op, input logic [4:0] amt);
    logic [63:0] w;
    w = {32'b0, op} << amt;
    return |w[63:32];
  endfunction

  // Waits for RDY with a bound; returns edges waited and cycles busy was seen high.
  task automatic wait_rdy(output int n, output int busy_cnt);
    n = 0;
    busy_cnt = 0;
    while (data_resultRDY !== 1'b1 && n < 20) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      n++;
    end
  endtask

  task automatic accept(input logic [31:0] op, input logic [4:0] amt);
    ctrl_SLL = 1'b1; data_operand = op; shiftamt = amt;
    tick();
    ctrl_SLL = 1'b0; data_operand = $urandom; shiftamt = 5'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [31:0] op, input logic [4:0] amt);
    int n, bc;
    accept(op, amt);
    wait_rdy(n, bc);
    chk({tag, "_lat"}, n, 5);
    chk({tag, "_busy"}, bc, 5);
    chk({tag, "_res"}, data_result, ref_res(op, amt));
    chk({tag, "_exc"}, {31'b0, data_exception}, {31'b0, ref_exc(op, amt)});
    tick();
    chk({tag, "_rdy_drop"}, {31'b0, data_resultRDY}, 0);
  endtask

  initial begin
    int n, bc;
    logic [31:0] op;
    logic [4:0]  amt;

    reset = 1'b1; ctrl_SLL = 1'b1; data_operand = 32'hFFFF_FFFF; shiftamt = 5'd3;
    // Reset with a pending request: nothing starts.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_res",  data_result, 0);
      chk("rst_rdy",  {31'b0, data_resultRDY}, 0);
      chk("rst_exc",  {31'b0, data_exception}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
    end
    reset = 1'b0; ctrl_SLL = 1'b0;
    tick();
    chk("post_rst_busy", {31'b0, busy}, 0);
    chk("post_rst_rdy",  {31'b0, data_resultRDY}, 0);

    run_op("basic", 32'h0000_00A5, 5'd4);
    chk("basic_const", data_result, 32'h0000_0A50);
    run_op("ovf1", 32'h8000_0001, 5'd1);
    chk("ovf1_const_exc", {31'b0, data_exception}, 1);
    run_op("ovf31", 32'h0000_0001, 5'd31);
    chk("ovf31_const", data_result, 32'h8000_0000);
    run_op("zero", 32'hDEAD_BEEF, 5'd0);
    chk("zero_const", data_result, 32'hDEAD_BEEF);
    run_op("max31", 32'h0000_0003, 5'd31);
    repeat (3) tick();
    chk("idle_hold_res", data_result, 32'h8000_0000);
    chk("idle_hold_exc", {31'b0, data_exception}, 1);

    // Request mid-SHIFT is dropped.
    accept(32'h1234_5678, 5'd8);
    tick();
    ctrl_SLL = 1'b1; data_operand = 32'hFFFF_FFFF; shiftamt = 5'd31;
    tick();
    ctrl_SLL = 1'b0;
    wait_rdy(n, bc);
    chk("midreq_lat", n, 3);
    chk("midreq_res", data_result, 32'h3456_7800);
    chk("midreq_exc", {31'b0, data_exception}, 1);
    tick();
    chk("midreq_no_restart", {31'b0, busy}, 0);

    // Back-to-back accept during DONE.
    accept(32'h0000_0F0F, 5'd2);
    wait_rdy(n, bc);
    chk("b2b_first_lat", n, 5);
    chk("b2b_first_res", data_result, 32'h0000_3C3C);
    ctrl_SLL = 1'b1; data_operand = 32'hC000_0001; shiftamt = 5'd3;
    tick();
    ctrl_SLL = 1'b0;
    chk("b2b_busy", {31'b0, busy}, 1);
    wait_rdy(n, bc);
    chk("b2b_second_gap", n + 1, 6);
    chk("b2b_second_res", data_result, 32'h0000_0008);
    chk("b2b_second_exc", {31'b0, data_exception}, 1);
    tick();

    // Reset on E3 aborts.
    accept(32'h0000_0001, 5'd5);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_res",  data_result, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_exc",  {31'b0, data_exception}, 0);
    bc = 0;
    for (int i = 0; i < 8; i++) begin
      if (data_resultRDY === 1'b1 || busy === 1'b1) bc++;
      tick();
    end
    chk("abort_no_rdy", bc, 0);
    run_op("after_abort", 32'h0000_0001, 5'd5);

    for (int i = 0; i < 1000; i++) begin
      op  = $urandom;
      amt = 5'($urandom_range(0, 31));
      if (i % 4 == 0) op = op >> $urandom_range(0, 31);
      run_op("rand", op, amt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sll_iter.md
# sll_iter

Iterative 32-bit logical left shifter with a start/ready handshake, the left-direction counterpart to the combinational arithmetic right shifter in the ALU datapath. It resolves one power-of-two shift stage per clock (16, 8, 4, 2, 1) and reuses a single shift register, which keeps the combinational path short. It also flags overflow when any 1 bit is shifted out of bit 31. It sits beside the multiplier/divider as a multicycle functional unit and uses the same ctrl/result/RDY/exception handshake.

## Interface

- No parameters. Data width is fixed at 32 and shift amount at 5 bits.
- clock  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clock.
- ctrl_SLL  input  1  start request, sampled on the rising edge; accepted only in IDLE or DONE.
- data_operand  input  32  value to shift; captured on the accepting edge.
- shiftamt  input  5  shift amount 0–31; captured on the accepting edge.
- data_result  output  32  shifted value; valid while data_resultRDY=1 and held until the next accept.
- data_resultRDY  output  1  high for exactly one cycle when the result is complete.
- data_exception  output  1  1 if any 1 bit was shifted past bit 31; valid with data_resultRDY and held with data_result.
- busy  output  1  high while in SHIFT.

## Operation

- State register: IDLE, SHIFT, DONE.
- Working registers: acc[31:0], amt[4:0], stage[2:0], exc.
- Accept occurs on an edge with ctrl_SLL=1 and state ∈ {IDLE, DONE}. On that edge:
  - acc←data_operand
  - amt←shiftamt
  - exc←0
  - stage←4
  - state←SHIFT
- Each edge in SHIFT, with s = 2^stage:
  - If amt[stage]=1: acc←{acc[31-s:0], s zeros} and exc←exc | (|acc[31:32-s]).
  - If amt[stage]=0: acc and exc are unchanged.
  - If stage=0: state←DONE. Otherwise stage←stage-1.
- All 5 stages always execute, so latency is fixed regardless of shiftamt.
- DONE lasts one cycle and then moves to IDLE unless a new accept occurs on that edge.
- ctrl_SLL in SHIFT is ignored; the request is dropped, not queued.
- Outputs:
  - data_result = acc
  - data_exception = exc
  - data_resultRDY = (state==DONE)
  - busy = (state==SHIFT)
- Width rules:
  - shiftamt=0 gives result = operand and exception 0.
  - shiftamt=31 gives result = {operand[0], 31 zeros}; exception = |operand[31:1].
  - The shift is logical: zeros fill from the LSB and there is no sign handling.

## Timing

- Reset:
  - state←IDLE; acc, amt, stage, exc ← 0.
  - Outputs after reset: data_result=0, data_resultRDY=0, data_exception=0, busy=0.
- Reset has priority over an accept on the same edge.
- Reset mid-SHIFT aborts the operation; no RDY pulse follows.
- Latency: accept on edge E0, stages on edges E1–E5, data_resultRDY=1 for the cycle between E5 and E6.
  - RDY is visible 5 cycles after the accepting edge.
- busy=1 for the 5 cycles between E0 and E5.
- Back-to-back: ctrl_SLL=1 during the DONE cycle is accepted on E6.
  - RDY is still 1 for that DONE cycle.
  - The old result is replaced on E6.
  - The next RDY is 5 cycles later.
  - Sustained throughput is one result per 6 cycles.
- In IDLE, data_result and data_exception hold the last result indefinitely.

## Test plan

- Reset check: assert reset 2 cycles with ctrl_SLL=1 -> all outputs 0, busy never rises, no RDY.
- Basic: operand=0x0000_00A5, shiftamt=4 -> RDY exactly 5 cycles after accept; result=0x0000_0A50, exception=0; busy high for 5 cycles.
- Overflow: operand=0x8000_0001, shiftamt=1 -> result=0x0000_0002, exception=1. Also operand=0x0000_0001, shiftamt=31 -> result=0x8000_0000, exception=0.
- Zero shift: operand=0xDEAD_BEEF, shiftamt=0 -> result=0xDEAD_BEEF, exception=0, still 5-cycle latency.
- Handshake:
  - Pulse ctrl_SLL mid-SHIFT with different operands -> ignored; the first result is unchanged.
  - Assert ctrl_SLL during the DONE cycle -> accepted; second RDY arrives 6 cycles after the first.
- Reset mid-operation: reset asserted on E3 -> outputs 0, no RDY. A fresh accept afterwards completes normally.
- Random: 1000 random operand/shiftamt pairs compared against (operand<<amt)[31:0], with exception = |(({32'b0,operand}<<amt)[63:32]).
